// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the data-RAM access controller.
// Contents: RAM size codes, read/write codes and the controller FSM state type.
package ram_access_ctrl_pkg;

  // Access size codes, shared with the RAM's Size port
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // Direction codes, shared with the RAM's RW port
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_rr_arbiter.sv
// Two-way request arbiter with optional round-robin fairness.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   req[1:0]    : request lines, bit 0 = m0, bit 1 = m1
//   enable      : grants are only issued while enable is high
//   gnt[1:0]    : one-hot (or zero) combinational grant
// RR_ARB = 1 alternates on ties, RR_ARB = 0 always favours m0.
module ram_rr_arbiter #(
  parameter int RR_ARB = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  // Index of the requester granted most recently (1 = m1)
  logic last_grant_q;
  logic last_grant_d;

  // Starts as "m1 last", so m0 wins the first tie after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (enable) begin
      if (req == 2'b11) begin
        // On a tie, round-robin hands the grant to whoever did not win last time
        if ((RR_ARB != 0) && !last_grant_q) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end else begin
        gnt = req;
      end
    end
    if (gnt[1]) begin
      last_grant_d = 1'b1;
    end else if (gnt[0]) begin
      last_grant_d = 1'b0;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer/arbiter in front of the asynchronous data RAM, shared by the CPU
// MEM stage (m0) and a loader/debug port (m1).
// Ports:
//   clk, reset                 : clock and asynchronous active-high reset
//   mX_req/rw/size/se/addr/wdata : request from requester X (held until mX_gnt)
//   mX_gnt                     : request accepted this cycle (IDLE only)
//   mX_rsp_valid/rdata/err     : one-cycle response to requester X
//   ram_A/DI/Size/RW/E/SE      : registered RAM control outputs
//   ram_DO                     : RAM read data
//   busy                       : controller not idle
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int RR_ARB    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [1:0]  m0_size,
  input  logic        m0_se,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [1:0]  m1_size,
  input  logic        m1_se,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [8:0]  ram_A,
  output logic [31:0] ram_DI,
  output logic [1:0]  ram_Size,
  output logic        ram_RW,
  output logic        ram_E,
  output logic        ram_SE,
  input  logic [31:0] ram_DO,
  output logic        busy
);

  localparam int ADDR_BITS = $clog2(MEM_BYTES);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  rsp_q, rsp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [8:0]  ram_a_q, ram_a_d;
  logic [31:0] ram_di_q, ram_di_d;
  logic [1:0]  ram_size_q, ram_size_d;
  logic        ram_rw_q, ram_rw_d;
  logic        ram_e_q, ram_e_d;
  logic        ram_se_q, ram_se_d;

  logic [1:0]  gnt;
  logic        sel_rw;
  logic [1:0]  sel_size;
  logic        sel_se;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;

  ram_rr_arbiter #(.RR_ARB(RR_ARB)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({m1_req, m0_req}),
    .enable (state_q == ST_IDLE),
    .gnt    (gnt)
  );

  // Steer the granted request onto one set of wires and classify it
  always_comb begin
    sel_rw    = gnt[1] ? m1_rw    : m0_rw;
    sel_size  = gnt[1] ? m1_size  : m0_size;
    sel_se    = gnt[1] ? m1_se    : m0_se;
    sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
    sel_err   = ((sel_addr >> ADDR_BITS) != 32'd0)
              || (sel_size == SZ_BAD)
              || ((sel_size == SZ_HALF) && sel_addr[0])
              || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
  end

  // Next-state logic; RAM controls are zero unless the next cycle is ACCESS,
  // so every RAM pin comes straight from a flop and E cannot glitch
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rsp_d      = 2'b00;
    rdata_d    = 32'd0;
    err_d      = 1'b0;
    ram_a_d    = 9'd0;
    ram_di_d   = 32'd0;
    ram_size_d = SZ_BYTE;
    ram_rw_d   = RW_READ;
    ram_e_d    = 1'b0;
    ram_se_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1];
          if (sel_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rsp_d   = gnt;
          end else begin
            state_d    = ST_ACCESS;
            ram_e_d    = 1'b1;
            ram_a_d    = sel_addr[8:0];
            ram_di_d   = sel_wdata;
            ram_size_d = sel_size;
            ram_rw_d   = sel_rw;
            ram_se_d   = sel_se;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        rsp_d   = owner_q ? 2'b10 : 2'b01;
        rdata_d = (ram_rw_q == RW_READ) ? ram_DO : 32'd0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset drops straight back to IDLE, discarding any pending response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rsp_q      <= 2'b00;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      ram_a_q    <= 9'd0;
      ram_di_q   <= 32'd0;
      ram_size_q <= SZ_BYTE;
      ram_rw_q   <= RW_READ;
      ram_e_q    <= 1'b0;
      ram_se_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rsp_q      <= rsp_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ram_a_q    <= ram_a_d;
      ram_di_q   <= ram_di_d;
      ram_size_q <= ram_size_d;
      ram_rw_q   <= ram_rw_d;
      ram_e_q    <= ram_e_d;
      ram_se_q   <= ram_se_d;
    end
  end

  // rdata_q/err_q are only non-zero during RESP; gate them to the owner
  always_comb begin
    m0_gnt       = gnt[0];
    m1_gnt       = gnt[1];
    m0_rsp_valid = rsp_q[0];
    m1_rsp_valid = rsp_q[1];
    m0_rdata     = rsp_q[0] ? rdata_q : 32'd0;
    m1_rdata     = rsp_q[1] ? rdata_q : 32'd0;
    m0_err       = rsp_q[0] & err_q;
    m1_err       = rsp_q[1] & err_q;
    ram_A        = ram_a_q;
    ram_DI       = ram_di_q;
    ram_Size     = ram_size_q;
    ram_RW       = ram_rw_q;
    ram_E        = ram_e_q;
    ram_SE       = ram_se_q;
    busy         = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: a table of single transactions
// against a big-endian RAM model, plus hand-written sequences for reset,
// arbitration (both modes) and reset during ACCESS.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  typedef struct {
    logic        port;
    logic        rw;
    logic [1:0]  size;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [31:0] FP_DO = 32'h5A5A_0F0F;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_rw, m0_se, m1_req, m1_rw, m1_se;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rsp_valid, m0_err, m1_gnt, m1_rsp_valid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [8:0]  ram_A;
  logic [31:0] ram_DI, ram_DO;
  logic [1:0]  ram_Size;
  logic        ram_RW, ram_E, ram_SE, busy;

  logic        fp_m0_req, fp_m1_req;
  logic        fp_m0_gnt, fp_m0_rsp_valid, fp_m0_err, fp_m1_gnt, fp_m1_rsp_valid, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic [8:0]  fp_ram_A;
  logic [31:0] fp_ram_DI, fp_ram_DO;
  logic [1:0]  fp_ram_Size;
  logic        fp_ram_RW, fp_ram_E, fp_ram_SE, fp_busy;

  int checks = 0;
  int errors = 0;

  vec_t vecs [20];
  logic [7:0] mem [0:511] = '{default: 8'h00};

  ram_access_ctrl #(.MEM_BYTES(512), .RR_ARB(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_size(m0_size), .m0_se(m0_se),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_size(m1_size), .m1_se(m1_se),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_A(ram_A), .ram_DI(ram_DI), .ram_Size(ram_Size), .ram_RW(ram_RW),
    .ram_E(ram_E), .ram_SE(ram_SE), .ram_DO(ram_DO), .busy(busy)
  );

  // Fixed-priority instance: both requesters issue word loads @0x10
  ram_access_ctrl #(.MEM_BYTES(512), .RR_ARB(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(fp_m0_req), .m0_rw(RW_READ), .m0_size(SZ_WORD), .m0_se(1'b0),
    .m0_addr(32'h10), .m0_wdata(32'h0), .m0_gnt(fp_m0_gnt),
    .m0_rsp_valid(fp_m0_rsp_valid), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(fp_m1_req), .m1_rw(RW_READ), .m1_size(SZ_WORD), .m1_se(1'b0),
    .m1_addr(32'h10), .m1_wdata(32'h0), .m1_gnt(fp_m1_gnt),
    .m1_rsp_valid(fp_m1_rsp_valid), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .ram_A(fp_ram_A), .ram_DI(fp_ram_DI), .ram_Size(fp_ram_Size), .ram_RW(fp_ram_RW),
    .ram_E(fp_ram_E), .ram_SE(fp_ram_SE), .ram_DO(fp_ram_DO), .busy(fp_busy)
  );

  assign fp_ram_DO = FP_DO;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian asynchronous RAM model: combinational read, write on the clock edge
  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    b0 = mem[ram_A];
    b1 = mem[ram_A + 9'd1];
    b2 = mem[ram_A + 9'd2];
    b3 = mem[ram_A + 9'd3];
    case (ram_Size)
      SZ_BYTE: ram_DO = ram_SE ? {{24{b0[7]}}, b0} : {24'h0, b0};
      SZ_HALF: ram_DO = ram_SE ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: ram_DO = {b0, b1, b2, b3};
    endcase
  end

  always @(posedge clk) begin
    if (ram_E && ram_RW) begin
      case (ram_Size)
        SZ_BYTE: mem[ram_A] <= ram_DI[7:0];
        SZ_HALF: begin
          mem[ram_A]        <= ram_DI[15:8];
          mem[ram_A + 9'd1] <= ram_DI[7:0];
        end
        default: begin
          mem[ram_A]        <= ram_DI[31:24];
          mem[ram_A + 9'd1] <= ram_DI[23:16];
          mem[ram_A + 9'd2] <= ram_DI[15:8];
          mem[ram_A + 9'd3] <= ram_DI[7:0];
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveReq(input vec_t v);
    if (v.port) begin
      m1_req = 1'b1; m1_rw = v.rw; m1_size = v.size; m1_se = v.se;
      m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_rw = v.rw; m0_size = v.size; m0_se = v.se;
      m0_addr = v.addr; m0_wdata = v.wdata;
    end
  endtask

  // Called just after the grant cycle's sample point; drops requests and
  // watches five cycles for the response and RAM enable activity
  task automatic runResponse(input string tag, input logic port, input logic exp_err,
                             input logic [31:0] exp_rdata);
    int lat = -1;
    int e_cnt = 0;
    int other = 0;
    logic [31:0] got_rdata = 32'hxxxx_xxxx;
    logic got_err = 1'bx;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      #1;
      if (ram_E) e_cnt++;
      if ((port ? m1_rsp_valid : m0_rsp_valid) && lat < 0) begin
        lat = c;
        got_rdata = port ? m1_rdata : m0_rdata;
        got_err = port ? m1_err : m0_err;
      end
      if (port ? m0_rsp_valid : m1_rsp_valid) other++;
    end
    checkOutput({tag, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    checkOutput({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
    checkOutput({tag, " rdata"}, got_rdata, exp_rdata);
    checkOutput({tag, " ram_E cycles"}, 32'(e_cnt), exp_err ? 32'd0 : 32'd1);
    checkOutput({tag, " other port rsp"}, 32'(other), 32'd0);
    checkOutput({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    bit granted = 0;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    driveReq(v);
    for (int w = 0; w < 8 && !granted; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      if (v.port ? m1_gnt : m0_gnt) granted = 1;
    end
    checkOutput({tag, " gnt"}, {31'd0, granted}, 32'd1);
    if (granted) begin
      runResponse(tag, v.port, v.exp_err, v.exp_rdata);
    end else begin
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
  endtask

  logic [11:0] g0, g1, f0, f1;
  int r0, r1, fr0, fbusy, no_rsp;
  logic fp_bad;

  initial begin
    // port, rw, size, se, addr, wdata, exp_err, exp_rdata
    vecs[0]  = '{1'b0, RW_WRITE, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, RW_READ,  SZ_WORD, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, RW_READ,  SZ_BYTE, 1'b1, 32'h010, 32'h0, 1'b0, 32'hFFFFFFDE};
    vecs[3]  = '{1'b1, RW_READ,  SZ_BYTE, 1'b0, 32'h010, 32'h0, 1'b0, 32'h000000DE};
    vecs[4]  = '{1'b1, RW_READ,  SZ_HALF, 1'b1, 32'h012, 32'h0, 1'b0, 32'hFFFFBEEF};
    vecs[5]  = '{1'b0, RW_READ,  SZ_HALF, 1'b0, 32'h011, 32'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, RW_READ,  SZ_WORD, 1'b0, 32'h012, 32'h0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, RW_READ,  SZ_BAD,  1'b0, 32'h010, 32'h0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, RW_READ,  SZ_WORD, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, RW_WRITE, SZ_WORD, 1'b0, 32'h012, 32'h11111111, 1'b1, 32'h0};
    vecs[10] = '{1'b1, RW_WRITE, SZ_BYTE, 1'b0, 32'h200, 32'h00000077, 1'b1, 32'h0};
    vecs[11] = '{1'b0, RW_READ,  SZ_WORD, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, RW_READ,  SZ_BYTE, 1'b0, 32'h000, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, RW_WRITE, SZ_WORD, 1'b0, 32'h1FC, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[14] = '{1'b1, RW_READ,  SZ_WORD, 1'b0, 32'h1FC, 32'h0, 1'b0, 32'hCAFEF00D};
    vecs[15] = '{1'b0, RW_READ,  SZ_HALF, 1'b0, 32'h010, 32'h0, 1'b0, 32'h0000DEAD};
    vecs[16] = '{1'b0, RW_WRITE, SZ_BYTE, 1'b0, 32'h013, 32'h000000A5, 1'b0, 32'h0};
    vecs[17] = '{1'b0, RW_READ,  SZ_WORD, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEA5};
    vecs[18] = '{1'b1, RW_WRITE, SZ_HALF, 1'b0, 32'h1FE, 32'hFFFF1234, 1'b0, 32'h0};
    vecs[19] = '{1'b0, RW_READ,  SZ_WORD, 1'b0, 32'h1FC, 32'h0, 1'b0, 32'hCAFE1234};

    reset = 1'b1;
    m0_req = 0; m0_rw = 0; m0_size = 0; m0_se = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_rw = 0; m1_size = 0; m1_se = 0; m1_addr = 0; m1_wdata = 0;
    fp_m0_req = 0; fp_m1_req = 0;

    // Reset state
    #3;
    checkOutput("reset flags", {22'd0, ram_E, ram_RW, ram_SE, ram_Size, busy,
                m0_rsp_valid, m1_rsp_valid, m0_err, m1_err}, 32'd0);
    checkOutput("reset ram_A", {23'd0, ram_A}, 32'd0);
    checkOutput("reset ram_DI", ram_DI, 32'd0);
    checkOutput("reset rdata", m0_rdata | m1_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Both requesters on every cycle, round-robin and fixed-priority side by side
    m0_req = 1; m0_rw = RW_READ; m0_size = SZ_WORD; m0_addr = 32'h10;
    m1_req = 1; m1_rw = RW_READ; m1_size = SZ_WORD; m1_addr = 32'h10;
    fp_m0_req = 1; fp_m1_req = 1;
    g0 = 0; g1 = 0; f0 = 0; f1 = 0; r0 = 0; r1 = 0; fr0 = 0; fbusy = 0; fp_bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      g0[c] = m0_gnt; g1[c] = m1_gnt; f0[c] = fp_m0_gnt; f1[c] = fp_m1_gnt;
      r0 += int'(m0_rsp_valid); r1 += int'(m1_rsp_valid);
      fr0 += int'(fp_m0_rsp_valid); fbusy += int'(fp_busy);
      if (fp_ram_E && ({fp_ram_A, fp_ram_Size, fp_ram_RW, fp_ram_SE, fp_ram_DI}
                       != {9'h010, SZ_WORD, RW_READ, 1'b0, 32'h0})) fp_bad = 1;
      if (fp_m0_rsp_valid && ((fp_m0_rdata != FP_DO) || fp_m0_err)) fp_bad = 1;
      if (fp_m1_rsp_valid || fp_m1_err || (fp_m1_rdata != 32'd0)) fp_bad = 1;
    end
    m0_req = 0; m1_req = 0; fp_m0_req = 0; fp_m1_req = 0;
    checkOutput("rr m0 grant cycles", {20'd0, g0}, 32'h041);
    checkOutput("rr m1 grant cycles", {20'd0, g1}, 32'h208);
    checkOutput("rr m0 responses", 32'(r0), 32'd2);
    checkOutput("rr m1 responses", 32'(r1), 32'd2);
    checkOutput("fp m0 grant cycles", {20'd0, f0}, 32'h249);
    checkOutput("fp m1 grant cycles", {20'd0, f1}, 32'h000);
    checkOutput("fp m0 responses", 32'(fr0), 32'd4);
    checkOutput("fp busy cycles", 32'(fbusy), 32'd8);
    checkOutput("fp response/ram values", {31'd0, fp_bad}, 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset while a load is in ACCESS
    @(negedge clk);
    driveReq('{1'b0, RW_READ, SZ_WORD, 1'b0, 32'h010, 32'h0, 1'b0, 32'h0});
    #1;
    checkOutput("rst-in-access gnt", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    checkOutput("rst-in-access ram_E before", {31'd0, ram_E}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst-in-access busy/ram_E", {30'd0, busy, ram_E}, 32'd0);
    reset = 1'b0;
    no_rsp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      no_rsp += int'(m0_rsp_valid) + int'(m1_rsp_valid);
    end
    checkOutput("rst-in-access discarded rsp", 32'(no_rsp), 32'd0);
    @(negedge clk);
    driveReq('{1'b0, RW_READ, SZ_WORD, 1'b0, 32'h010, 32'h0, 1'b0, 32'h0});
    driveReq('{1'b1, RW_READ, SZ_WORD, 1'b0, 32'h1FC, 32'h0, 1'b0, 32'h0});
    #1;
    checkOutput("post-reset tie gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    runResponse("post-reset m0", 1'b0, 1'b0, 32'hDEADBEA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
